dflow_replay_ctrl: RTL and testbench
====================================

Name: dflow_replay_ctrl

Overview:
- Sequences read-back of the stored dflow tuple region in QDR memory after the store phase completes.
- Issues read commands over [dflow_addr_low, dflow_addr_high] and wraps for a programmed number of replay passes.
- Limits in-flight reads with a credit counter and forwards returned words into the downstream packet-generator FIFO.
- Sits beside fifo_to_mem on the QDR user read port.

Parameters:
MEM_ADDR_WIDTH, 19, QDR user address width
MEM_DATA_WIDTH, 144, read data width (QDR_DATA_WIDTH*QDR_BURST_LENGTH)
REPLAY_COUNT_WIDTH, 32, width of pass counter
MAX_OUTSTANDING, 16, max read commands in flight (power of 2, ≥2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cal_done  in  1  QDR calibration complete
start_replay  in  1  one-cycle pulse; start a replay run
sw_stop  in  1  one-cycle pulse; abort the run
dflow_addr_low  in  MEM_ADDR_WIDTH  first replay address
dflow_addr_high  in  MEM_ADDR_WIDTH  last replay address (inclusive)
replay_count  in  REPLAY_COUNT_WIDTH  passes; 0 = endless
issue_gap  in  16  minimum cycles between commands (see Optional Feature)
app_rd_cmd  out  1  read command valid
app_rd_addr  out  MEM_ADDR_WIDTH  read address
app_rd_rdy  in  1  memory accepts command this cycle
app_rd_valid  in  1  read data valid
app_rd_data  in  MEM_DATA_WIDTH  read data
out_wr_en  out  1  downstream FIFO write
out_data  out  MEM_DATA_WIDTH  downstream FIFO data
out_nearly_full  in  1  downstream FIFO nearly full
busy  out  1  run in progress
done  out  1  run finished (level)
err  out  1  sticky error
pass_cnt  out  REPLAY_COUNT_WIDTH  completed passes

Behaviour:
- Reset values: app_rd_cmd=0, app_rd_addr=0, out_wr_en=0, out_data=0, busy=0, done=0, err=0, pass_cnt=0, outstanding=0, state=IDLE.
- States: IDLE, WAIT_CAL, ISSUE, DRAIN, DONE.
- IDLE:
  - start_replay latches low, high and count, clears done, err and pass_cnt, and sets busy.
  - If low>high: err=1, go to DONE; no command is issued.
  - Otherwise go to WAIT_CAL.
- WAIT_CAL: go to ISSUE the cycle after cal_done=1.
- ISSUE:
  - app_rd_cmd=1 while outstanding<MAX_OUTSTANDING and out_nearly_full=0 (and the gap is satisfied).
  - The command is accepted when app_rd_cmd&app_rd_rdy.
  - app_rd_cmd/app_rd_addr are held stable until accepted, even if the issue conditions deassert.
  - On accept: outstanding+1, and address+1. At high, address wraps to low and pass_cnt+1.
  - If count≠0 and the incremented pass_cnt==count: go to DRAIN.
- DRAIN: no commands issued. When outstanding==0, go to DONE.
- DONE: done=1, busy=0, go to IDLE. done holds until the next start_replay.
- sw_stop in WAIT_CAL/ISSUE: go to DRAIN. A command already presented but not yet accepted is withdrawn. sw_stop in other states is ignored.
- start_replay while busy: ignored.
- outstanding counter:
  - Decrements on app_rd_valid.
  - Accept and valid in the same cycle leave it unchanged.
  - app_rd_valid with outstanding==0: data still forwarded, err=1, counter stays 0.
- Data path: out_wr_en and out_data are registered copies of app_rd_valid and app_rd_data (1-cycle latency), forwarded in every state including DRAIN.
- Downstream FIFO must keep ≥MAX_OUTSTANDING+2 free entries when asserting nearly_full.
- Address arithmetic: modulo 2^MEM_ADDR_WIDTH; low==high replays a single word.
- pass_cnt saturates at all-ones.
- rst mid-run: everything returns to reset values immediately; in-flight read data arriving after reset is forwarded but not counted.

Optional Feature:
- Macro: DFLOW_REPLAY_RATE_LIMIT_EN.
- Defined:
  - After each accepted command, a gap counter loads issue_gap.
  - app_rd_cmd stays 0 until the counter reaches 0.
  - issue_gap=0 or 1 allows back-to-back issue.
  - issue_gap is sampled at start_replay.
- Undefined: issue_gap is ignored and commands may issue every cycle; the gap counter is not built.

Test Plan:
- low=0x10, high=0x13, count=2, app_rd_rdy=1, read latency 5 -> 8 commands with addresses 0x10..0x13 twice; pass_cnt=2; 8 out_wr_en; done=1 after last data; err=0.
- MAX_OUTSTANDING=16, read data withheld -> exactly 16 commands then stall; release data -> issue resumes; outstanding never exceeds 16.
- out_nearly_full=1 mid-ISSUE -> app_rd_cmd drops after the pending command is accepted; deassert -> resumes at the next address, no address skipped or repeated.
- count=0, sw_stop after 37 accepts -> no further commands; done=1 once all 37 data words are returned; pass_cnt=37/range.
- low=0x20, high=0x1F -> err=1, done=1, zero commands issued; app_rd_valid with outstanding=0 -> err=1, data forwarded.
- DFLOW_REPLAY_RATE_LIMIT_EN defined, issue_gap=4 -> consecutive accepted commands are exactly 4 cycles apart.

Source files
------------

// File: rtl/dflow_replay_ctrl.sv
// dflow_replay_ctrl
//
// Replays the stored dflow tuple region out of QDR memory once the store
// phase has finished. Read commands sweep [dflow_addr_low, dflow_addr_high],
// wrapping for replay_count passes (0 = endless). A credit counter bounds the
// reads in flight, and returned words go straight to the packet-generator
// FIFO. The block shares the QDR user read port with fifo_to_mem.
//
// Optional build macro: DFLOW_REPLAY_RATE_LIMIT_EN
//   defined   -> a down-counter keeps commands at least issue_gap cycles apart
//                (issue_gap is sampled at start_replay; 0 or 1 = back-to-back)
//   undefined -> issue_gap is ignored and commands may issue every cycle
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   cal_done            QDR calibration complete
//   start_replay        pulse: start a run (ignored while a run is active)
//   sw_stop             pulse: abort the run (honoured in WAIT_CAL / ISSUE)
//   dflow_addr_low/high inclusive replay window
//   replay_count        number of passes, 0 = endless
//   issue_gap           minimum cycles between commands (rate-limit build)
//   app_rd_cmd/addr     read command to memory, held until app_rd_rdy
//   app_rd_rdy          memory accepts the command this cycle
//   app_rd_valid/data   read data returning from memory
//   out_wr_en/out_data  registered copy of the read data to the FIFO
//   out_nearly_full     FIFO back-pressure (needs MAX_OUTSTANDING+2 slack)
//   busy, done, err     run status; err is sticky until the next start
//   pass_cnt            completed passes, saturating
//
// State table
//   state    | meaning
//   IDLE     | waiting for start_replay
//   WAIT_CAL | run armed, waiting for QDR calibration
//   ISSUE    | issuing read commands under credit / back-pressure control
//   DRAIN    | no new commands, waiting for in-flight reads to return
//   DONE     | one-cycle completion state, raises done, drops busy

module dflow_replay_ctrl #(
    parameter int MEM_ADDR_WIDTH     = 19,
    parameter int MEM_DATA_WIDTH     = 144,
    parameter int REPLAY_COUNT_WIDTH = 32,
    parameter int MAX_OUTSTANDING    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cal_done,
    input  logic                          start_replay,
    input  logic                          sw_stop,
    input  logic [MEM_ADDR_WIDTH-1:0]     dflow_addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0]     dflow_addr_high,
    input  logic [REPLAY_COUNT_WIDTH-1:0] replay_count,
    input  logic [15:0]                   issue_gap,
    output logic                          app_rd_cmd,
    output logic [MEM_ADDR_WIDTH-1:0]     app_rd_addr,
    input  logic                          app_rd_rdy,
    input  logic                          app_rd_valid,
    input  logic [MEM_DATA_WIDTH-1:0]     app_rd_data,
    output logic                          out_wr_en,
    output logic [MEM_DATA_WIDTH-1:0]     out_data,
    input  logic                          out_nearly_full,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [REPLAY_COUNT_WIDTH-1:0] pass_cnt
);

    localparam int               OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CAL,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t                          state, state_next;
    logic [MEM_ADDR_WIDTH-1:0]       lo_q, hi_q, addr_q;
    logic [REPLAY_COUNT_WIDTH-1:0]   cnt_q;
    logic [REPLAY_COUNT_WIDTH-1:0]   pass_inc;
    logic [OUT_W-1:0]                outstanding, outstanding_next;
    logic                            cmd_q, cmd_next;
    logic                            accept;
    logic                            start_ok;
    logic                            range_bad;
    logic                            at_high;
    logic                            pass_hit;
    logic                            gap_ok_next;

    assign accept    = cmd_q & app_rd_rdy;
    assign start_ok  = start_replay & ((state == IDLE) | (state == DONE));
    assign range_bad = dflow_addr_low > dflow_addr_high;
    assign at_high   = addr_q == hi_q;
    assign pass_inc  = (&pass_cnt) ? pass_cnt : pass_cnt + 1'b1;
    assign pass_hit  = accept & at_high & (cnt_q != '0) & (pass_inc == cnt_q);

    assign app_rd_cmd  = cmd_q;
    assign app_rd_addr = addr_q;

`ifdef DFLOW_REPLAY_RATE_LIMIT_EN
    logic [15:0] gap_cfg, gap_q, gap_next;

    // Loaded with gap-1 on accept so that reaching zero on the next-cycle
    // value lines the following command up exactly issue_gap cycles later.
    always_comb begin
        gap_next = gap_q;
        if (accept) begin
            gap_next = (gap_cfg == '0) ? '0 : gap_cfg - 1'b1;
        end else if (gap_q != '0) begin
            gap_next = gap_q - 1'b1;
        end
    end

    assign gap_ok_next = gap_next == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cfg <= '0;
            gap_q   <= '0;
        end else begin
            gap_q <= gap_next;
            if (start_ok) begin
                gap_cfg <= issue_gap;
                gap_q   <= '0;
            end
        end
    end
`else
    logic unused_issue_gap;
    assign unused_issue_gap = ^issue_gap;
    assign gap_ok_next      = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start_replay) begin
                    state_next = range_bad ? DONE : WAIT_CAL;
                end else if (state == DONE) begin
                    state_next = IDLE;
                end
            end
            WAIT_CAL: begin
                if (sw_stop) begin
                    state_next = DRAIN;
                end else if (cal_done) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (sw_stop || pass_hit) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Data with no read outstanding is orphaned: it is still forwarded and
    // flagged, but it must not pull the credit counter below zero.
    always_comb begin
        outstanding_next = outstanding;
        if (accept && !(app_rd_valid && outstanding != '0)) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!accept && app_rd_valid && outstanding != '0) begin
            outstanding_next = outstanding - 1'b1;
        end
    end

    // The command is a register: once presented it stays until taken, and
    // leaving ISSUE (stop or final pass) withdraws it.
    always_comb begin
        cmd_next = 1'b0;
        if (state_next == ISSUE) begin
            if (cmd_q && !app_rd_rdy) begin
                cmd_next = 1'b1;
            end else begin
                cmd_next = (outstanding_next < MAX_OUT) && !out_nearly_full && gap_ok_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q       <= 1'b0;
            outstanding <= '0;
            addr_q      <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            cnt_q       <= '0;
            pass_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            out_wr_en   <= 1'b0;
            out_data    <= '0;
        end else begin
            cmd_q       <= cmd_next;
            outstanding <= outstanding_next;
            out_wr_en   <= app_rd_valid;
            out_data    <= app_rd_data;

            if (app_rd_valid && outstanding == '0) begin
                err <= 1'b1;
            end

            if (start_ok) begin
                lo_q     <= dflow_addr_low;
                hi_q     <= dflow_addr_high;
                cnt_q    <= replay_count;
                addr_q   <= dflow_addr_low;
                pass_cnt <= '0;
                done     <= 1'b0;
                err      <= range_bad;
                busy     <= 1'b1;
            end else if (accept) begin
                addr_q <= at_high ? lo_q : addr_q + 1'b1;
                if (at_high) begin
                    pass_cnt <= pass_inc;
                end
            end

            if (state_next == DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dflow_replay_ctrl.sv
module tb_dflow_replay_ctrl;

    localparam int AW   = 19;
    localparam int DW   = 144;
    localparam int CW   = 32;
    localparam int MAXO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cal_done;
    logic          start_replay;
    logic          sw_stop;
    logic [AW-1:0] dflow_addr_low;
    logic [AW-1:0] dflow_addr_high;
    logic [CW-1:0] replay_count;
    logic [15:0]   issue_gap;
    logic          app_rd_cmd;
    logic [AW-1:0] app_rd_addr;
    logic          app_rd_rdy;
    logic          app_rd_valid;
    logic [DW-1:0] app_rd_data;
    logic          out_wr_en;
    logic [DW-1:0] out_data;
    logic          out_nearly_full;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] pass_cnt;

    always #5 clk = ~clk;

    dflow_replay_ctrl #(
        .MEM_ADDR_WIDTH    (AW),
        .MEM_DATA_WIDTH    (DW),
        .REPLAY_COUNT_WIDTH(CW),
        .MAX_OUTSTANDING   (MAXO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cal_done       (cal_done),
        .start_replay   (start_replay),
        .sw_stop        (sw_stop),
        .dflow_addr_low (dflow_addr_low),
        .dflow_addr_high(dflow_addr_high),
        .replay_count   (replay_count),
        .issue_gap      (issue_gap),
        .app_rd_cmd     (app_rd_cmd),
        .app_rd_addr    (app_rd_addr),
        .app_rd_rdy     (app_rd_rdy),
        .app_rd_valid   (app_rd_valid),
        .app_rd_data    (app_rd_data),
        .out_wr_en      (out_wr_en),
        .out_data       (out_data),
        .out_nearly_full(out_nearly_full),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .pass_cnt       (pass_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory / environment model
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend[$];
    int            acc_cyc[$];
    int            cyc        = 0;
    int            last_due   = 0;
    int            rdy_mode   = 1;
    int            lat_min    = 5;
    int            lat_max    = 5;
    bit            withhold   = 0;
    bit            rdy_block  = 0;
    bit            nf_rand    = 0;
    bit            inj_valid  = 0;
    logic [DW-1:0] inj_data   = '0;
    bit            prev_valid = 0;
    logic [DW-1:0] prev_data  = '0;
    int            n_acc      = 0;
    int            n_fwd      = 0;
    int            inflight   = 0;
    logic [AW-1:0] m_lo       = '0;
    int            m_range    = 1;

    // One clock cycle; entered and left at a falling edge.
    task automatic step();
        logic [159:0]  r;
        logic [AW-1:0] exp_addr;
        rd_t           e;
        chk("fwd_en", out_wr_en, prev_valid);
        if (prev_valid) chk("fwd_data", out_data, prev_data);
        if (out_wr_en) n_fwd++;

        if (nf_rand) out_nearly_full = ($urandom_range(0, 7) == 0);
        case (rdy_mode)
            0:       app_rd_rdy = 1'b0;
            1:       app_rd_rdy = 1'b1;
            default: app_rd_rdy = 1'($urandom_range(0, 1));
        endcase
        if (rdy_block) app_rd_rdy = 1'b0;

        if (app_rd_cmd && app_rd_rdy) begin
            // i-th accepted command of a run reads low + (i mod range)
            exp_addr = m_lo + AW'(n_acc % m_range);
            chk("addr", app_rd_addr, exp_addr);
            chk("credit", inflight < MAXO, 1);
            n_acc++;
            inflight++;
            acc_cyc.push_back(cyc);
            r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            e.data = r[DW-1:0];
            e.due  = cyc + $urandom_range(lat_min, lat_max);
            if (e.due <= last_due) e.due = last_due + 1;
            last_due = e.due;
            pend.push_back(e);
        end

        app_rd_valid = 1'b0;
        app_rd_data  = '0;
        if (inj_valid) begin
            app_rd_valid = 1'b1;
            app_rd_data  = inj_data;
        end else if (!withhold && pend.size() > 0 && pend[0].due <= cyc) begin
            e = pend.pop_front();
            app_rd_valid = 1'b1;
            app_rd_data  = e.data;
            inflight--;
        end
        prev_valid = app_rd_valid;
        prev_data  = app_rd_data;

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_run(input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                             input logic [CW-1:0] cnt, input logic [15:0] gap);
        dflow_addr_low  = lo;
        dflow_addr_high = hi;
        replay_count    = cnt;
        issue_gap       = gap;
        m_lo            = lo;
        m_range         = (hi >= lo) ? int'(hi - lo) + 1 : 1;
        n_acc           = 0;
        n_fwd           = 0;
        acc_cyc.delete();
        start_replay = 1'b1;
        step();
        start_replay = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) step();
        chk("done_reached", done, 1);
        repeat (3) step();
    endtask

    typedef struct {
        logic [AW-1:0] lo;
        logic [AW-1:0] hi;
        logic [CW-1:0] cnt;
        int            rdy;
        int            lat;
        int            exp_cmds;
        int            exp_pass;
        bit            exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int            n_hold;
        logic [AW-1:0] held_addr;
        int            lo_r;
        int            rng_r;
        int            cnt_r;

        vecs[0] = '{19'h10,    19'h13,    32'd2, 1, 5, 8,  2, 1'b0};
        vecs[1] = '{19'h20,    19'h1F,    32'd1, 1, 5, 0,  0, 1'b1};
        vecs[2] = '{19'h5,     19'h5,     32'd3, 2, 3, 3,  3, 1'b0};
        vecs[3] = '{19'h7FFFD, 19'h7FFFF, 32'd2, 1, 2, 6,  2, 1'b0};
        vecs[4] = '{19'h100,   19'h107,   32'd1, 2, 7, 8,  1, 1'b0};
        vecs[5] = '{19'h0,     19'h2,     32'd4, 2, 1, 12, 4, 1'b0};

        rst             = 1'b1;
        cal_done        = 1'b0;
        start_replay    = 1'b0;
        sw_stop         = 1'b0;
        dflow_addr_low  = '0;
        dflow_addr_high = '0;
        replay_count    = '0;
        issue_gap       = '0;
        app_rd_rdy      = 1'b0;
        app_rd_valid    = 1'b0;
        app_rd_data     = '0;
        out_nearly_full = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_cmd",  app_rd_cmd, 0);
        chk("rst_addr", app_rd_addr, 0);
        chk("rst_wr",   out_wr_en, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err",  err, 0);
        chk("rst_pass", pass_cnt, 0);

        rst = 1'b0;
        step();
        cal_done = 1'b1;
        step();

        // Table-driven runs
        for (int v = 0; v < 6; v++) begin
            rdy_mode = vecs[v].rdy;
            lat_min  = vecs[v].lat;
            lat_max  = vecs[v].lat;
            start_run(vecs[v].lo, vecs[v].hi, vecs[v].cnt, 16'd0);
            wait_done(3000);
            chk("vec_cmds", n_acc, vecs[v].exp_cmds);
            chk("vec_fwd",  n_fwd, vecs[v].exp_cmds);
            chk("vec_pass", pass_cnt, vecs[v].exp_pass);
            chk("vec_err",  err, vecs[v].exp_err);
            chk("vec_busy", busy, 0);
        end

        // Orphan read data while idle: forwarded and flagged
        inj_valid = 1'b1;
        inj_data  = {16'hBEEF, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978};
        step();
        inj_valid = 1'b0;
        chk("orphan_err", err, 1);
        step();

        // Read data withheld: credit limit stalls issue at MAX_OUTSTANDING
        rdy_mode = 1;
        lat_min  = 2;
        lat_max  = 2;
        withhold = 1'b1;
        start_run(19'h0, 19'd99, 32'd1, 16'd0);
        chk("orphan_cleared", err, 0);
        repeat (40) step();
        chk("stall_cmds", n_acc, MAXO);
        chk("stall_cmd_low", app_rd_cmd, 0);
        chk("stall_busy", busy, 1);
        withhold = 1'b0;
        wait_done(3000);
        chk("stall_total", n_acc, 100);
        chk("stall_fwd", n_fwd, 100);

        // Back-pressure: pending command held, then issue pauses and resumes
        lat_min = 3;
        lat_max = 3;
        start_run(19'h200, 19'h21D, 32'd1, 16'd0);
        for (int i = 0; i < 200 && n_acc < 5; i++) step();
        rdy_block       = 1'b1;
        out_nearly_full = 1'b1;
        held_addr       = app_rd_addr;
        step();
        chk("nf_hold_cmd", app_rd_cmd, 1);
        chk("nf_hold_addr", app_rd_addr, held_addr);
        step();
        chk("nf_hold_cmd2", app_rd_cmd, 1);
        rdy_block = 1'b0;
        step();
        n_hold = n_acc;
        repeat (6) step();
        chk("nf_no_issue", n_acc, n_hold);
        chk("nf_cmd_low", app_rd_cmd, 0);
        out_nearly_full = 1'b0;
        wait_done(3000);
        chk("nf_total", n_acc, 30);

        // Endless replay stopped by software after 37 accepts
        rdy_mode = 2;
        lat_min  = 1;
        lat_max  = 6;
        start_run(19'h40, 19'h49, 32'd0, 16'd0);
        for (int i = 0; i < 3000 && n_acc < 37; i++) step();
        sw_stop   = 1'b1;
        rdy_block = 1'b1;
        step();
        sw_stop   = 1'b0;
        rdy_block = 1'b0;
        wait_done(3000);
        chk("stop_cmds", n_acc, 37);
        chk("stop_fwd",  n_fwd, 37);
        chk("stop_pass", pass_cnt, 3);
        chk("stop_err",  err, 0);

        // Randomised runs against the address/pass model
        nf_rand = 1'b1;
        lat_min = 1;
        lat_max = 8;
        for (int t = 0; t < 6; t++) begin
            lo_r  = $urandom_range(0, 1000);
            rng_r = $urandom_range(1, 12);
            cnt_r = $urandom_range(1, 3);
            start_run(AW'(lo_r), AW'(lo_r + rng_r - 1), CW'(cnt_r), 16'd0);
            wait_done(5000);
            chk("rnd_cmds", n_acc, rng_r * cnt_r);
            chk("rnd_fwd",  n_fwd, rng_r * cnt_r);
            chk("rnd_pass", pass_cnt, cnt_r);
            chk("rnd_err",  err, 0);
        end
        nf_rand         = 1'b0;
        out_nearly_full = 1'b0;

        // Issue spacing
        rdy_mode = 1;
        lat_min  = 2;
        lat_max  = 2;
`ifdef DFLOW_REPLAY_RATE_LIMIT_EN
        start_run(19'h300, 19'h30B, 32'd1, 16'd4);
        wait_done(3000);
        chk("gap_cmds", n_acc, 12);
        for (int i = 1; i < acc_cyc.size(); i++) chk("gap4", acc_cyc[i] - acc_cyc[i-1], 4);
        start_run(19'h300, 19'h305, 32'd1, 16'd1);
        wait_done(3000);
        for (int i = 1; i < acc_cyc.size(); i++) chk("gap1", acc_cyc[i] - acc_cyc[i-1], 1);
`else
        start_run(19'h300, 19'h30B, 32'd1, 16'd4);
        wait_done(3000);
        chk("nogap_cmds", n_acc, 12);
        for (int i = 1; i < acc_cyc.size(); i++) chk("nogap", acc_cyc[i] - acc_cyc[i-1], 1);
`endif

        // Reset in the middle of a run
        lat_min = 4;
        lat_max = 4;
        start_run(19'h0, 19'd50, 32'd1, 16'd0);
        repeat (10) step();
        rst = 1'b1;
        #1;
        chk("mrst_cmd",  app_rd_cmd, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_pass", pass_cnt, 0);
        chk("mrst_wr",   out_wr_en, 0);
        pend.delete();
        inflight     = 0;
        prev_valid   = 1'b0;
        app_rd_valid = 1'b0;
        app_rd_data  = '0;
        @(negedge clk);
        rst = 1'b0;
        n_hold = n_acc;
        repeat (5) step();
        chk("mrst_idle", n_acc, n_hold);
        chk("mrst_busy2", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
